// File: rtl/pipelined_register_file.sv
// Register file with write-back forwarding and a busy scoreboard that tracks
// destination registers reserved by in-flight producers.
module pipelined_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_a,
    input  logic              flush,
    output logic [ADDR_W:0]   pending_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              wr_ok;
    logic              rsv_ok;

    assign wr_ok  = we3 && !(ZERO_REG && a3 == '0);
    assign rsv_ok = rsv_en && !(ZERO_REG && rsv_a == '0);

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = regs_q[a];
        if (BYPASS && we3 && a == a3) v = wd3;
        if (ZERO_REG && a == '0) v = '0;
        return v;
    endfunction

    // A forwarded write frees the register now, unless a new producer claims it.
    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = busy_q[a];
        if (BYPASS && we3 && a == a3 && !(rsv_en && rsv_a == a)) b = 1'b0;
        if (ZERO_REG && a == '0) b = 1'b0;
        return b;
    endfunction

    assign rd1         = read_data(a1);
    assign rd2         = read_data(a2);
    assign busy1       = read_busy(a1);
    assign busy2       = read_busy(a2);
    assign pending_cnt = cnt_q;

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[a3] = wd3;
    end

    always_comb begin
        busy_d = busy_q;
        if (we3) busy_d[a3] = 1'b0;
        if (rsv_ok) busy_d[rsv_a] = 1'b1;
        if (flush) busy_d = '0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipelined_register_file.sv
// Bench for pipelined_register_file: directed vector table, corner sequences
// and random traffic against a set-based reference model.
module tb_pipelined_register_file;
    logic        clk = 1'b0;
    logic        reset, we3, rsv_en, flush;
    logic [4:0]  a1, a2, a3, rsv_a;
    logic [31:0] wd3;
    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_bz1, b_bz2, n_bz1, n_bz2;
    logic [5:0]  b_cnt, n_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [32];
    bit          pend [int];

    always #5 clk = ~clk;

    pipelined_register_file u_byp (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2),
        .rd1(b_rd1), .rd2(b_rd2), .busy1(b_bz1), .busy2(b_bz2),
        .we3(we3), .a3(a3), .wd3(wd3), .rsv_en(rsv_en), .rsv_a(rsv_a),
        .flush(flush), .pending_cnt(b_cnt)
    );

    pipelined_register_file #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2),
        .rd1(n_rd1), .rd2(n_rd2), .busy1(n_bz1), .busy2(n_bz2),
        .we3(we3), .a3(a3), .wd3(wd3), .rsv_en(rsv_en), .rsv_a(rsv_a),
        .flush(flush), .pending_cnt(n_cnt)
    );

    typedef struct {
        logic        we3;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        rsv_en;
        logic [4:0]  rsv_a;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_nb_rd2;
        logic        e_b1;
        logic        e_b2;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we3 && a == a3) return wd3;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && we3 && a == a3 && !(rsv_en && rsv_a == a)) return 1'b0;
        return pend.exists(int'(a));
    endfunction

    task automatic check_model();
        logic [31:0] cnt;
        cnt = pend.num();
        chk("byp_rd1", b_rd1, exp_rd(a1, 1'b1));
        chk("byp_rd2", b_rd2, exp_rd(a2, 1'b1));
        chk("byp_busy1", {31'd0, b_bz1}, {31'd0, exp_busy(a1, 1'b1)});
        chk("byp_busy2", {31'd0, b_bz2}, {31'd0, exp_busy(a2, 1'b1)});
        chk("byp_cnt", {26'd0, b_cnt}, cnt);
        chk("nb_rd1", n_rd1, exp_rd(a1, 1'b0));
        chk("nb_rd2", n_rd2, exp_rd(a2, 1'b0));
        chk("nb_busy1", {31'd0, n_bz1}, {31'd0, exp_busy(a1, 1'b0)});
        chk("nb_busy2", {31'd0, n_bz2}, {31'd0, exp_busy(a2, 1'b0)});
        chk("nb_cnt", {26'd0, n_cnt}, cnt);
    endtask

    task automatic model_edge();
        if (reset) begin
            foreach (mem_m[i]) mem_m[i] = 32'd0;
            pend.delete();
        end else begin
            if (we3 && a3 != 5'd0) mem_m[a3] = wd3;
            if (flush) begin
                pend.delete();
            end else begin
                if (we3) pend.delete(int'(a3));
                if (rsv_en && rsv_a != 5'd0) pend[int'(rsv_a)] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 0; we3 = 0; rsv_en = 0; flush = 0;
        a3 = 0; wd3 = 0; rsv_a = 0;
    endtask

    initial begin
        idle();
        a1 = 0; a2 = 0;
        reset = 1;
        tick();
        tick();
        idle();

        vecs[0]  = '{0, 0, 0, 0, 0, 5, 31, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 6,
                     32'hDEADBEEF, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 5, 5,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
        vecs[3]  = '{1, 7, 32'h12345678, 0, 0, 7, 7,
                     32'h12345678, 32'h12345678, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 7,
                     0, 32'h12345678, 32'h12345678, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 3, 0, 7,
                     0, 32'h12345678, 32'h12345678, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 1, 4, 3, 4, 0, 0, 0, 1, 0, 1};
        vecs[7]  = '{0, 0, 0, 0, 0, 3, 4, 0, 0, 0, 1, 1, 2};
        vecs[8]  = '{1, 3, 32'hAAAA0003, 0, 0, 3, 4,
                     32'hAAAA0003, 0, 0, 0, 1, 2};
        vecs[9]  = '{1, 4, 32'hBBBB0004, 1, 4, 3, 4,
                     32'hAAAA0003, 32'hBBBB0004, 0, 0, 1, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 3, 4,
                     32'hAAAA0003, 32'hBBBB0004, 32'hBBBB0004, 0, 1, 1};

        for (int i = 0; i < 11; i++) begin
            we3 = vecs[i].we3; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
            rsv_en = vecs[i].rsv_en; rsv_a = vecs[i].rsv_a;
            a1 = vecs[i].a1; a2 = vecs[i].a2;
            #1;
            chk($sformatf("vec%0d_rd1", i), b_rd1, vecs[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i), b_rd2, vecs[i].e_rd2);
            chk($sformatf("vec%0d_nb_rd2", i), n_rd2, vecs[i].e_nb_rd2);
            chk($sformatf("vec%0d_busy1", i), {31'd0, b_bz1}, {31'd0, vecs[i].e_b1});
            chk($sformatf("vec%0d_busy2", i), {31'd0, b_bz2}, {31'd0, vecs[i].e_b2});
            chk($sformatf("vec%0d_cnt", i), {26'd0, b_cnt}, {26'd0, vecs[i].e_cnt});
            tick();
        end
        idle();

        // Fill every reservable register, then flush with a discarded reserve.
        for (int r = 1; r < 32; r++) begin
            rsv_en = 1; rsv_a = 5'(r); a1 = 5'(r); a2 = 5'(r - 1);
            #1;
            check_model();
            tick();
        end
        idle();
        #1;
        chk("fill_cnt", {26'd0, b_cnt}, 32'd31);
        check_model();
        tick();
        flush = 1; rsv_en = 1; rsv_a = 9;
        we3 = 1; a3 = 10; wd3 = 32'hCAFE0010;
        a1 = 9; a2 = 10;
        #1;
        check_model();
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            #1;
            chk("flush_cnt", {26'd0, b_cnt}, 32'd0);
            chk("flush_busy1", {31'd0, b_bz1}, 32'd0);
            check_model();
            if (i == 3) chk("flush_keep3", b_rd1, 32'hAAAA0003);
            if (i == 10) chk("flush_wr10", b_rd1, 32'hCAFE0010);
            tick();
        end

        // Reset in the middle of writes and reservations.
        we3 = 1; a3 = 12; wd3 = 32'h0000_1212; rsv_en = 1; rsv_a = 14;
        #1; check_model(); tick();
        we3 = 1; a3 = 13; wd3 = 32'h0000_1313; rsv_en = 1; rsv_a = 15;
        #1; check_model(); tick();
        reset = 1; we3 = 1; a3 = 12; wd3 = 32'h5555_5555;
        rsv_en = 1; rsv_a = 20; flush = 0;
        #1; tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            #1;
            chk("rst_rd1", b_rd1, 32'd0);
            chk("rst_rd2", n_rd2, 32'd0);
            chk("rst_busy1", {31'd0, b_bz1}, 32'd0);
            chk("rst_cnt", {26'd0, b_cnt}, 32'd0);
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(63) == 0);
            flush  = ($urandom_range(15) == 0);
            we3    = $urandom_range(1);
            rsv_en = $urandom_range(1);
            a3     = 5'($urandom_range(31));
            rsv_a  = ($urandom_range(3) == 0) ? a3 : 5'($urandom_range(31));
            wd3    = $urandom;
            a1     = ($urandom_range(2) == 0) ? a3 : 5'($urandom_range(31));
            a2     = ($urandom_range(3) == 0) ? rsv_a : 5'($urandom_range(31));
            #1;
            check_model();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_register_file.md
PIPELINED_REGISTER_FILE -- requirements
Module: pipelined_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads as 0, ignores writes and is never busy.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to the read ports.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports a1, a2, input, ADDR_W: read addresses.
REQ-008 SHALL have ports rd1, rd2, output, DATA_W: combinational read data.
REQ-009 SHALL have ports busy1, busy2, output, 1: the addressed register has a pending write.
REQ-010 SHALL have ports we3, input, 1, a3, input, ADDR_W, and wd3, input, DATA_W: the write-back port.
REQ-011 SHALL have ports rsv_en, input, 1, and rsv_a, input, ADDR_W: reserve a destination register (mark it busy).
REQ-012 SHALL have port flush, input, 1: clear all busy bits and keep register contents.
REQ-013 SHALL have port pending_cnt, output, ADDR_W+1: number of busy registers.

Function
REQ-014 SHALL hold DEPTH x DATA_W data registers and a DEPTH-bit busy vector.
REQ-015 SHALL write wd3 into register a3 on a clk edge when we3=1 and reset=0, except register 0 when ZERO_REG=1.
REQ-016 SHALL drive rd1/rd2 combinationally from the addressed register: no read latency.
REQ-017 SHALL drive wd3 on rdN when BYPASS=1, we3=1 and aN==a3 (and not register 0 with ZERO_REG=1); when BYPASS=0 it SHALL show the old value until the edge.
REQ-018 SHALL drive rdN=0 and busyN=0 when ZERO_REG=1 and aN==0.
REQ-019 SHALL set busy[rsv_a] on an edge with rsv_en=1 (ignored for register 0 when ZERO_REG=1).
REQ-020 SHALL clear busy[a3] on an edge with we3=1.
REQ-021 SHALL leave busy[x] set when rsv_en=1 and we3=1 with rsv_a==a3==x on the same edge (reservation wins: the new producer owns the register); the data write still occurs.
REQ-022 SHALL drive busyN combinationally as busy[aN], deasserting it in the same cycle when BYPASS=1, we3=1, a3==aN and no same-address reservation.
REQ-023 SHALL clear the whole busy vector and set pending_cnt=0 on an edge with flush=1; a same-edge we3 write SHALL still update data, and a same-edge rsv_en SHALL be discarded.
REQ-024 SHALL register pending_cnt as the population count of the busy vector after each edge: +1 on a set of a free register, -1 on a clear of a busy register, 0 net change when both happen.
REQ-025 SHALL make reserving an already-busy register and writing a non-busy register legal, with no count change from that event.
REQ-026 SHALL keep pending_cnt in 0..DEPTH (DEPTH-ZERO_REG maximum) without wrap.

Reset
REQ-027 SHALL, on an edge with reset=1, set all data registers to 0, clear all busy bits and set pending_cnt=0; reset SHALL override we3, rsv_en and flush.
REQ-028 SHALL drive rd1=rd2=0, busy1=busy2=0 and pending_cnt=0 in the cycle after reset, for any address.
REQ-029 SHALL discard all reservations and pending writes when reset is asserted mid-operation, with no partial state kept.

Verification
REQ-030 SHALL cover basic write/read: reset; we3=1, a3=5, wd3=0xDEADBEEF; next cycle a1=5 -> rd1=0xDEADBEEF, busy1=0.
REQ-031 SHALL cover bypass: a3=7, wd3=0x12345678, we3=1, a2=7 in the same cycle -> rd2=0x12345678 before the edge (BYPASS=1); old value shown with BYPASS=0.
REQ-032 SHALL cover register zero: we3=1, a3=0, wd3=0xFFFFFFFF; rsv_en=1, rsv_a=0 -> rd1=0 at a1=0, busy1=0, pending_cnt unchanged.
REQ-033 SHALL cover the scoreboard: reserve 3, then 4 -> pending_cnt=2, busy at a1=3 is 1; write 3 -> pending_cnt=1, busy1=0; same-edge reserve+write to 4 -> busy stays 1, pending_cnt=1.
REQ-034 SHALL cover flush and fill: reserve registers 1..31 -> pending_cnt=31; flush with same-edge rsv_en=1, rsv_a=9 -> pending_cnt=0, all busy 0, data intact.
REQ-035 SHALL cover reset mid-operation: registers written and reserved, reset=1 for one edge with we3=1 -> all reads 0, pending_cnt=0.
